spectrum_peak_finder: RTL and testbench

//  Stream sink for the 32-bit power-per-bin output of the magnitude-squared stage in the FFT peripheral.

---
 rtl/spectrum_peak_finder.sv | 118 +++++++++++
 tb/tb_spectrum_peak_finder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_finder.sv
// Spectrum peak finder: consumes one FFT frame of unsigned power values,
// tracks the strongest bin and its index, sums the frame energy and offers
// the result on a valid/ready port. Upstream is stalled while a result waits.
module spectrum_peak_finder #(
  parameter int FFT_LEN = 1024,
  parameter int IDX_W   = 10,
  parameter int DATA_W  = 32,
  parameter bit SKIP_DC = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_data_valid,
  input  logic                    i_data_last,
  output logic                    o_data_ready,
  output logic [IDX_W-1:0]        o_peak_idx,
  output logic [DATA_W-1:0]       o_peak_pwr,
  output logic [DATA_W+IDX_W-1:0] o_energy,
  output logic [IDX_W:0]          o_bin_count,
  output logic                    o_peak_valid,
  input  logic                    i_peak_ready
);

  localparam int CNT_W = IDX_W + 1;
  localparam int EN_W  = DATA_W + IDX_W;
  localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] FIRST_BIN = CNT_W'(SKIP_DC ? 1 : 0);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] max_pwr;
  logic [IDX_W-1:0]  max_idx;
  logic [EN_W-1:0]   energy;

  logic              beat;
  logic              close;
  logic              eligible;
  logic              take;
  logic [EN_W-1:0]   energy_sum;
  logic [DATA_W-1:0] max_pwr_nxt;
  logic [IDX_W-1:0]  max_idx_nxt;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign o_data_ready = i_rst_n && (state == ACCUM);
  assign o_peak_valid = (state == HOLD);

  assign beat  = i_data_valid && o_data_ready;
  assign close = beat && (i_data_last || (cnt == LAST_BIN));

  // With DC skipping, bin 0 never competes; the first eligible bin seeds the max.
  assign eligible    = !(SKIP_DC && (cnt == '0));
  assign take        = eligible && ((cnt == FIRST_BIN) || (i_data > max_pwr));
  assign energy_sum  = energy + EN_W'(i_data);
  assign max_pwr_nxt = take ? i_data : max_pwr;
  assign max_idx_nxt = take ? cnt[IDX_W-1:0] : max_idx;

  // Next-state logic: close a frame into HOLD, release on result handshake.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close)        state_nxt = HOLD;
      HOLD:    if (i_peak_ready) state_nxt = ACCUM;
      default:                   state_nxt = ACCUM;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ACCUM;
    else          state <= state_nxt;
  end

  // Running accumulators: updated on each beat, cleared when the frame closes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      max_pwr <= '0;
      max_idx <= '0;
      energy  <= '0;
    end else if (beat) begin
      if (close) begin
        cnt     <= '0;
        max_pwr <= '0;
        max_idx <= '0;
        energy  <= '0;
      end else begin
        cnt     <= cnt + 1'b1;
        max_pwr <= max_pwr_nxt;
        max_idx <= max_idx_nxt;
        energy  <= energy_sum;
      end
    end
  end

  // Result registers capture the frame including the closing beat and hold afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_peak_idx  <= '0;
      o_peak_pwr  <= '0;
      o_energy    <= '0;
      o_bin_count <= '0;
    end else if (close) begin
      o_peak_idx  <= max_idx_nxt;
      o_peak_pwr  <= max_pwr_nxt;
      o_energy    <= energy_sum;
      o_bin_count <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed bench for spectrum_peak_finder with FFT_LEN=8. Two instances share
// the stimulus: one searches all bins, the other skips the DC bin.
module tb_spectrum_peak_finder;

  localparam int FFT_LEN = 8;
  localparam int IDX_W   = 3;
  localparam int DATA_W  = 32;
  localparam int EN_W    = DATA_W + IDX_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   data;
  logic                data_valid;
  logic                data_last;
  logic                peak_ready;

  logic                rdy_a, rdy_b;
  logic [IDX_W-1:0]    idx_a, idx_b;
  logic [DATA_W-1:0]   pwr_a, pwr_b;
  logic [EN_W-1:0]     en_a, en_b;
  logic [IDX_W:0]      cnt_a, cnt_b;
  logic                vld_a, vld_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spectrum_peak_finder #(.FFT_LEN(FFT_LEN), .IDX_W(IDX_W), .DATA_W(DATA_W), .SKIP_DC(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_data_valid(data_valid),
    .i_data_last(data_last), .o_data_ready(rdy_a), .o_peak_idx(idx_a),
    .o_peak_pwr(pwr_a), .o_energy(en_a), .o_bin_count(cnt_a),
    .o_peak_valid(vld_a), .i_peak_ready(peak_ready)
  );

  spectrum_peak_finder #(.FFT_LEN(FFT_LEN), .IDX_W(IDX_W), .DATA_W(DATA_W), .SKIP_DC(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_data_valid(data_valid),
    .i_data_last(data_last), .o_data_ready(rdy_b), .o_peak_idx(idx_b),
    .o_peak_pwr(pwr_b), .o_energy(en_b), .o_bin_count(cnt_b),
    .o_peak_valid(vld_b), .i_peak_ready(peak_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait for it to be taken (bounded).
  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    int n;
    data       = d;
    data_last  = l;
    data_valid = 1'b1;
    n = 0;
    while (!rdy_a && n < 50) begin
      tick();
      n++;
    end
    if (!rdy_a) check("beat_timeout", {63'd0, rdy_a}, 64'd1);
    tick();
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] v [8]);
    for (int i = 0; i < 8; i++) send(v[i], 1'b0);
  endtask

  task automatic handshake();
    peak_ready = 1'b1;
    tick();
    peak_ready = 1'b0;
    check("hs_valid_drop", {63'd0, vld_a}, 64'd0);
    check("hs_ready_back", {63'd0, rdy_a}, 64'd1);
  endtask

  logic [DATA_W-1:0] frame [8];
  logic [IDX_W-1:0]  h_idx;
  logic [DATA_W-1:0] h_pwr;
  logic [EN_W-1:0]   h_en;
  bit                stable;

  initial begin
    rst_n = 1'b0; data = '0; data_valid = 1'b0; data_last = 1'b0; peak_ready = 1'b0;
    tick();
    tick();
    check("rst_ready",  {63'd0, rdy_a}, 64'd0);
    check("rst_valid",  {63'd0, vld_a}, 64'd0);
    check("rst_energy", 64'(en_a), 64'd0);
    check("rst_count",  64'(cnt_a), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {63'd0, rdy_a}, 64'd1);

    // 1: basic frame with a tie at bins 1 and 3
    frame = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd2, 32'd7};
    send_frame(frame);
    check("t1_valid",  {63'd0, vld_a}, 64'd1);
    check("t1_idx",    64'(idx_a), 64'd1);
    check("t1_pwr",    64'(pwr_a), 64'd9);
    check("t1_energy", 64'(en_a), 64'd36);
    check("t1_count",  64'(cnt_a), 64'd8);
    check("t1_ready",  {63'd0, rdy_a}, 64'd0);
    check("t1s_idx",   64'(idx_b), 64'd1);
    check("t1s_pwr",   64'(pwr_b), 64'd9);
    handshake();

    // 2: strong DC bin only wins when DC is searched
    frame = '{32'd100, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd2, 32'd7};
    send_frame(frame);
    check("t2_idx",     64'(idx_a), 64'd0);
    check("t2_pwr",     64'(pwr_a), 64'd100);
    check("t2s_idx",    64'(idx_b), 64'd1);
    check("t2s_pwr",    64'(pwr_b), 64'd9);
    check("t2s_energy", 64'(en_b), 64'd131);
    check("t2s_count",  64'(cnt_b), 64'd8);
    handshake();

    // 3: early close on the 4th beat
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    send(32'd40, 1'b1);
    check("t3_valid",  {63'd0, vld_a}, 64'd1);
    check("t3_idx",    64'(idx_a), 64'd3);
    check("t3_pwr",    64'(pwr_a), 64'd40);
    check("t3_energy", 64'(en_a), 64'd100);
    check("t3_count",  64'(cnt_a), 64'd4);

    // 4: backpressure while the result is pending
    h_idx = idx_a; h_pwr = pwr_a; h_en = en_a;
    data = 32'd50; data_last = 1'b0; data_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy_a || !vld_a || idx_a != h_idx || pwr_a != h_pwr || en_a != h_en) stable = 1'b0;
    end
    check("t4_stall_stable", {63'd0, stable}, 64'd1);
    check("t4_stall_ready",  {63'd0, rdy_a}, 64'd0);
    handshake();
    send(32'd50, 1'b0);
    send(32'd60, 1'b1);
    check("t4_count",  64'(cnt_a), 64'd2);
    check("t4_energy", 64'(en_a), 64'd110);
    check("t4_idx",    64'(idx_a), 64'd1);
    check("t4_pwr",    64'(pwr_a), 64'd60);
    handshake();

    // 5: all-ones frame, energy at full width, ties keep lowest index
    for (int i = 0; i < 8; i++) frame[i] = 32'hFFFF_FFFF;
    send_frame(frame);
    check("t5_idx",    64'(idx_a), 64'd0);
    check("t5_pwr",    64'(pwr_a), 64'hFFFF_FFFF);
    check("t5_energy", 64'(en_a), 64'h7_FFFF_FFF8);
    check("t5s_idx",   64'(idx_b), 64'd1);
    handshake();

    // 6: reset mid-frame, then a clean frame of ones
    send(32'd3, 1'b0);
    send(32'd3, 1'b0);
    send(32'd3, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t6_rst_ready",  {63'd0, rdy_a}, 64'd0);
    check("t6_rst_energy", 64'(en_a), 64'd0);
    rst_n = 1'b1;
    tick();
    check("t6_no_pulse", {63'd0, vld_a}, 64'd0);
    for (int i = 0; i < 7; i++) send(32'd1, 1'b0);
    check("t6_pre_valid", {63'd0, vld_a}, 64'd0);
    send(32'd1, 1'b0);
    check("t6_valid",  {63'd0, vld_a}, 64'd1);
    check("t6_energy", 64'(en_a), 64'd8);
    check("t6_count",  64'(cnt_a), 64'd8);
    check("t6_idx",    64'(idx_a), 64'd0);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
